// File: rtl/elevator_pkg.sv
// Shared types and constants for the passenger side of the elevator request path.
// Hall bit layout: bit 2(f-1)+1 is the UP call and bit 2(f-1) is the DOWN call for floor f.
package elevator_pkg;

  localparam int NUM_FLOORS = 7;
  localparam int NUM_HALL   = 2 * NUM_FLOORS;
  localparam int NUM_CAB    = NUM_FLOORS + 2;

  localparam logic [1:0] UP   = 2'b10;
  localparam logic [1:0] DOWN = 2'b01;
  localparam logic       OPEN = 1'b1;
  localparam logic       MOVE = 1'b1;

  typedef enum logic [1:0] {IDLE, ARMED, HELD, RELEASE} deb_state_e;

  // Only meaningful for floors 1..NUM_FLOORS.
  function automatic logic [3:0] hallBit(input logic [2:0] floor, input logic [1:0] dir);
    return {floor - 3'd1, dir == UP};
  endfunction

endpackage

// File: rtl/call_debouncer.sv
// One pushbutton: 2-FF synchronizer, then a tick-paced debounce FSM that emits a
// single-cycle press per physical push and a level while the button is considered held.
module call_debouncer
  import elevator_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic raw,
  output logic press,
  output logic level
);

  logic       sync1_q, sync2_q;
  deb_state_e state_q;
  logic       press_q, level_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      press_q <= 1'b0;
      level_q <= 1'b0;
    end else begin
      press_q <= 1'b0;
      if (tick) begin
        unique case (state_q)
          IDLE:    if (sync2_q) state_q <= ARMED;
          ARMED: begin
            if (sync2_q) begin
              state_q <= HELD;
              press_q <= 1'b1;
              level_q <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end
          HELD:    if (!sync2_q) state_q <= RELEASE;
          // A bounce back to high re-enters HELD without a second press.
          RELEASE: begin
            if (sync2_q) begin
              state_q <= HELD;
            end else begin
              state_q <= IDLE;
              level_q <= 1'b0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign press = press_q;
  assign level = level_q;

endmodule

// File: rtl/call_panel.sv
// Hall/cab call front end: debounces raw switches, latches calls for the Elevator core,
// and clears each call when the core's served echo for that bit falls.
module call_panel
  import elevator_pkg::*;
#(
  parameter int CLK_PER_SAMPLE = 10000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_HALL-1:0] rawFloorButton,
  input  logic [NUM_CAB:1]    rawInternalButton,
  input  logic [NUM_HALL-1:0] servedFloorButton,
  input  logic [NUM_CAB:1]    servedInternalButton,
  input  logic [2:0]          currentFloor,
  input  logic                doorState,
  input  logic                move,
  output logic [NUM_HALL-1:0] floorButton,
  output logic [NUM_CAB:1]    internalButton,
  output logic                callPending
);

  localparam int            CW      = (CLK_PER_SAMPLE > 1) ? $clog2(CLK_PER_SAMPLE) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_PER_SAMPLE - 1);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  tick;
  logic [NUM_HALL-1:0]   hall_press, hall_level, hall_ok;
  logic [NUM_CAB:1]      cab_press, cab_level;
  logic [NUM_FLOORS:1]   cab_ok;
  logic                  supp_active;
  logic [NUM_HALL-1:0]   floor_q, floor_d, served_floor_q;
  logic [NUM_FLOORS:1]   cab_q, cab_d, served_cab_q;
  logic                  unused_bits;

  for (genvar i = 0; i < NUM_HALL; i++) begin : g_hall
    call_debouncer u_deb (
      .clk(clk), .reset(reset), .tick(tick), .raw(rawFloorButton[i]),
      .press(hall_press[i]), .level(hall_level[i])
    );
  end

  for (genvar i = 1; i <= NUM_CAB; i++) begin : g_cab
    call_debouncer u_deb (
      .clk(clk), .reset(reset), .tick(tick), .raw(rawInternalButton[i]),
      .press(cab_press[i]), .level(cab_level[i])
    );
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    tick  = (cnt_q == CNT_MAX);
    cnt_d = tick ? '0 : cnt_q + 1'b1;

    supp_active = (doorState == OPEN) && (move != MOVE) &&
                  (currentFloor != 3'd0) && (int'(currentFloor) <= NUM_FLOORS);

    hall_ok = '1;
    hall_ok[hallBit(3'd1, DOWN)]              = 1'b0;
    hall_ok[hallBit(3'(NUM_FLOORS), UP)]      = 1'b0;
    cab_ok  = '1;
    // The car is parked open at this floor, so a call here is already satisfied.
    if (supp_active) begin
      cab_ok[currentFloor]                    = 1'b0;
      hall_ok[hallBit(currentFloor, UP)]      = 1'b0;
      hall_ok[hallBit(currentFloor, DOWN)]    = 1'b0;
    end

    // Clear on the falling edge of the served echo; a same-cycle press wins.
    floor_d = (floor_q & ~(served_floor_q & ~servedFloorButton)) | (hall_press & hall_ok);
    cab_d   = (cab_q & ~(served_cab_q & ~servedInternalButton[NUM_FLOORS:1])) |
              (cab_press[NUM_FLOORS:1] & cab_ok);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q          <= '0;
      floor_q        <= '0;
      cab_q          <= '0;
      served_floor_q <= '0;
      served_cab_q   <= '0;
    end else begin
      cnt_q          <= cnt_d;
      floor_q        <= floor_d;
      cab_q          <= cab_d;
      served_floor_q <= servedFloorButton;
      served_cab_q   <= servedInternalButton[NUM_FLOORS:1];
    end
  end

  assign floorButton    = floor_q;
  assign internalButton = {cab_level[NUM_CAB:NUM_FLOORS+1], cab_q};
  assign callPending    = (|floor_q) | (|cab_q);

  // Door buttons are never served-cleared and hall levels have no consumer.
  assign unused_bits = ^{hall_level, cab_level[NUM_FLOORS:1],
                         cab_press[NUM_CAB:NUM_FLOORS+1],
                         servedInternalButton[NUM_CAB:NUM_FLOORS+1]};

endmodule

// File: tb/tb_call_panel.sv
// Directed bench for call_panel with a 4-cycle debounce sample period.
module tb_call_panel;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [13:0] rawFloorButton = '0;
  logic [9:1]  rawInternalButton = '0;
  logic [13:0] servedFloorButton = '0;
  logic [9:1]  servedInternalButton = '0;
  logic [2:0]  currentFloor = 3'd1;
  logic        doorState = 1'b0;
  logic        move = 1'b0;
  logic [13:0] floorButton;
  logic [9:1]  internalButton;
  logic        callPending;

  int checks = 0;
  int failures = 0;
  int cab5_presses = 0;
  int hall6_presses = 0;

  call_panel #(.CLK_PER_SAMPLE(4)) dut (
    .clk(clk), .reset(reset),
    .rawFloorButton(rawFloorButton), .rawInternalButton(rawInternalButton),
    .servedFloorButton(servedFloorButton), .servedInternalButton(servedInternalButton),
    .currentFloor(currentFloor), .doorState(doorState), .move(move),
    .floorButton(floorButton), .internalButton(internalButton), .callPending(callPending)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dut.cab_press[5])  cab5_presses++;
    if (dut.hall_press[6]) hall6_presses++;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold the given buttons for 12 cycles, then release and let the FSMs settle to IDLE.
  task automatic push(input logic [13:0] h, input logic [9:1] c);
    cyc(1);
    rawFloorButton    = rawFloorButton | h;
    rawInternalButton = rawInternalButton | c;
    cyc(12);
    rawFloorButton    = rawFloorButton & ~h;
    rawInternalButton = rawInternalButton & ~c;
    cyc(14);
  endtask

  task automatic served_pulse(input logic [13:0] h, input logic [9:1] c);
    servedFloorButton = h; servedInternalButton = c;
    cyc(1);
    servedFloorButton = '0; servedInternalButton = '0;
    cyc(1);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    cyc(3);
    checks++; if (floorButton !== 14'h0) begin failures++; $display("FAIL reset_floor: got %h expected 0000", floorButton); end
    checks++; if (internalButton !== 9'h0) begin failures++; $display("FAIL reset_internal: got %b expected 000000000", internalButton); end
    checks++; if (callPending !== 1'b0) begin failures++; $display("FAIL reset_pending: got %b expected 0", callPending); end
    reset = 1'b1;
    cyc(1);
  endtask

  task automatic test_cab_latch;
    int lat = 0;
    int base = cab5_presses;
    rawInternalButton[5] = 1'b1;
    for (int i = 1; i <= 26; i++) begin
      cyc(1);
      if (i == 12) rawInternalButton[5] = 1'b0;
      if (lat == 0 && internalButton[5] === 1'b1) lat = i;
    end
    checks++; if (lat < 8 || lat > 11) begin failures++; $display("FAIL cab5_latency: got %0d cycles expected 8..11", lat); end
    checks++; if (internalButton !== 9'b000010000) begin failures++; $display("FAIL cab5_latched: got %b expected 000010000", internalButton); end
    checks++; if (callPending !== 1'b1) begin failures++; $display("FAIL cab5_pending: got %b expected 1", callPending); end
    checks++; if (cab5_presses - base !== 1) begin failures++; $display("FAIL cab5_press_count: got %0d expected 1", cab5_presses - base); end
    served_pulse('0, 9'b000010000);
    checks++; if (internalButton !== 9'h0) begin failures++; $display("FAIL cab5_cleared: got %b expected 000000000", internalButton); end
    checks++; if (callPending !== 1'b0) begin failures++; $display("FAIL cab5_pending_clear: got %b expected 0", callPending); end
  endtask

  task automatic test_glitch;
    int base = hall6_presses;
    rawFloorButton[6] = 1'b1; cyc(1);
    rawFloorButton[6] = 1'b0; cyc(6);
    rawFloorButton[6] = 1'b1; cyc(3);
    rawFloorButton[6] = 1'b0; cyc(14);
    checks++; if (floorButton !== 14'h0) begin failures++; $display("FAIL glitch_floor: got %h expected 0000", floorButton); end
    checks++; if (hall6_presses - base !== 0) begin failures++; $display("FAIL glitch_presses: got %0d expected 0", hall6_presses - base); end
  endtask

  task automatic test_clear;
    push(14'h0008, '0);
    checks++; if (floorButton !== 14'h0008) begin failures++; $display("FAIL hall3_latched_no_clear: got %h expected 0008", floorButton); end
    servedFloorButton[3] = 1'b1;
    cyc(1);
    checks++; if (floorButton !== 14'h0008) begin failures++; $display("FAIL hall3_served_high: got %h expected 0008", floorButton); end
    servedFloorButton[3] = 1'b0;
    #1;
    checks++; if (floorButton !== 14'h0008) begin failures++; $display("FAIL hall3_before_edge: got %h expected 0008", floorButton); end
    cyc(1);
    checks++; if (floorButton !== 14'h0000) begin failures++; $display("FAIL hall3_cleared: got %h expected 0000", floorButton); end
  endtask

  task automatic test_press_wins;
    bit hit = 1'b0;
    push(14'h0010, '0);
    servedFloorButton[4] = 1'b1;
    cyc(2);
    rawFloorButton[4] = 1'b1;
    for (int i = 0; i < 30 && !hit; i++) begin
      cyc(1);
      if (dut.hall_press[4] === 1'b1) begin
        servedFloorButton[4] = 1'b0;
        hit = 1'b1;
      end
    end
    checks++; if (!hit) begin failures++; $display("FAIL press_wins_timeout: got no press expected press within 30 cycles"); end
    cyc(1);
    checks++; if (floorButton !== 14'h0010) begin failures++; $display("FAIL press_wins: got %h expected 0010", floorButton); end
    rawFloorButton[4] = 1'b0;
    cyc(16);
    checks++; if (floorButton !== 14'h0010) begin failures++; $display("FAIL press_wins_hold: got %h expected 0010", floorButton); end
    served_pulse(14'h0010, '0);
    checks++; if (floorButton !== 14'h0000) begin failures++; $display("FAIL hall4_cleared: got %h expected 0000", floorButton); end
  endtask

  task automatic test_suppress;
    currentFloor = 3'd3; doorState = 1'b1; move = 1'b0;
    push(14'h0020, 9'b000000100);
    checks++; if (floorButton !== 14'h0000) begin failures++; $display("FAIL suppress_hall: got %h expected 0000", floorButton); end
    checks++; if (internalButton !== 9'h0) begin failures++; $display("FAIL suppress_cab: got %b expected 000000000", internalButton); end
    move = 1'b1;
    push(14'h0020, 9'b000000100);
    checks++; if (floorButton !== 14'h0020) begin failures++; $display("FAIL moving_hall: got %h expected 0020", floorButton); end
    checks++; if (internalButton !== 9'b000000100) begin failures++; $display("FAIL moving_cab: got %b expected 000000100", internalButton); end
    move = 1'b0; doorState = 1'b0;
    push(14'h2001, '0);
    checks++; if (floorButton !== 14'h0020) begin failures++; $display("FAIL illegal_hall: got %h expected 0020", floorButton); end
    currentFloor = 3'd0; doorState = 1'b1;
    push('0, 9'b000000010);
    checks++; if (internalButton !== 9'b000000110) begin failures++; $display("FAIL floor0_no_suppress: got %b expected 000000110", internalButton); end
    doorState = 1'b0; currentFloor = 3'd1;
  endtask

  task automatic test_reset_mid;
    bit seen = 1'b0;
    rawInternalButton[8] = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      cyc(1);
      if (internalButton[8] === 1'b1) seen = 1'b1;
    end
    checks++; if (!seen) begin failures++; $display("FAIL door8_level_timeout: got 0 expected 1 within 20 cycles"); end
    cyc(2);
    reset = 1'b0;
    #1;
    checks++; if (floorButton !== 14'h0) begin failures++; $display("FAIL midreset_floor: got %h expected 0000", floorButton); end
    checks++; if (internalButton !== 9'h0) begin failures++; $display("FAIL midreset_internal: got %b expected 000000000", internalButton); end
    checks++; if (callPending !== 1'b0) begin failures++; $display("FAIL midreset_pending: got %b expected 0", callPending); end
    cyc(3);
    reset = 1'b1;
    cyc(3);
    checks++; if (internalButton !== 9'h0) begin failures++; $display("FAIL post_reset_internal: got %b expected 000000000", internalButton); end
    checks++; if (callPending !== 1'b0) begin failures++; $display("FAIL post_reset_pending: got %b expected 0", callPending); end
    rawInternalButton[8] = 1'b0;
    cyc(20);
    checks++; if (internalButton[8] !== 1'b0) begin failures++; $display("FAIL door8_released: got %b expected 0", internalButton[8]); end
    push('0, 9'b000000010);
    checks++; if (internalButton !== 9'b000000010) begin failures++; $display("FAIL repush_cab2: got %b expected 000000010", internalButton); end
  endtask

  initial begin
    test_reset();
    test_cab_latch();
    test_glitch();
    test_clear();
    test_press_wins();
    test_suppress();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
